clkgate_ctrl: RTL and testbench
===============================

# clkgate_ctrl

Per-domain clock-gating controller for banks of CLKGATETST-style gating cells (inputs CK, E, SE; output GCK). Each domain has an idle counter and a three-state FSM. Together they drive the cell's E input: a domain's clock is gated after a programmable idle period and re-enabled on request, and a ready flag marks when the gated clock is usable. A test-mode input forces every clock on through SE. The block sits beside the gating cells in the clock/power management layer.

## Interface
- N_DOM, 4, number of gated clock domains (1..32)
- IDLE_CYCLES, 16, consecutive idle samples before gating (>=1)
- WAKE_CYCLES, 2, edges from wake sample to RDY (>=1)
- CK  in  1  ungated clock; all state updates on rising edge
- RST  in  1  reset, synchronous, active-high
- TEST_MODE  in  1  scan/test override
- REQ  in  N_DOM  domain i needs its clock
- FORCE_ON  in  N_DOM  software override, treated as REQ
- E  out  N_DOM  enable to gating cell i, registered
- SE  out  1  test enable to all gating cells, registered copy of TEST_MODE
- RDY  out  N_DOM  domain i clock running and stable
- GATED  out  N_DOM  domain i in OFF state
- ALL_GATED  out  1  AND of GATED

## Operation
- Per-domain states: RUN (E=1, RDY=1), OFF (E=0, RDY=0), WAKE (E=1, RDY=0); counter cnt.
- act_i = REQ[i] | FORCE_ON[i].
- RUN:
  - act_i=1: cnt<=0.
  - act_i=0 and cnt==IDLE_CYCLES-1: go to OFF, cnt<=0.
  - Otherwise cnt<=cnt+1.
- OFF: act_i=1 goes to WAKE with cnt<=0; otherwise hold.
- WAKE:
  - cnt==WAKE_CYCLES-1: go to RUN, cnt<=0.
  - Otherwise cnt<=cnt+1.
  - act_i is ignored; there is no abort path. A dropped request re-enters idle counting in RUN.
- Simultaneous events: act_i=1 on the same edge the idle limit is reached keeps the domain in RUN with cnt<=0.
- TEST_MODE=1 at an edge:
  - Every domain goes to RUN with cnt<=0.
  - Domains are held in RUN while TEST_MODE=1.
  - SE<=1.
- TEST_MODE falling: normal counting resumes from cnt=0.
- Reset: all domains RUN, cnt=0. Reset outputs are E=all 1, RDY=all 1, GATED=0, ALL_GATED=0, SE=0.
- RST asserted mid-WAKE or in OFF returns the domain to RUN the next edge, E=1.
- Counter width is $clog2(max(IDLE_CYCLES,WAKE_CYCLES)) bits, minimum 1. The counter never exceeds its limit; no wrap.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Gating latency: if act_i first samples 0 at edge k, E[i] falls after edge k+IDLE_CYCLES-1. GCK stops on the following cycle, because the cell latches E while CK is low.
- Wake latency: act_i=1 sampled in OFF at edge k:
  - E[i]=1 after edge k.
  - RDY[i]=1 after edge k+WAKE_CYCLES.
  - The first GCK pulse arrives at edge k+1.
- SE follows TEST_MODE with 1 cycle of latency.
- Domains are fully independent. There is no arbitration or limit on simultaneous wakes.

## Structure
- Package clkgate_ctrl_pkg holds:
  - the state enum {ST_RUN, ST_OFF, ST_WAKE}, 2-bit encoding;
  - the cnt width function.
- One sub-module, clkgate_dom_fsm: single-domain FSM plus counter, with ports CK, RST, TEST_MODE, act, E, RDY, GATED.
- Top level: generate loop over N_DOM, the SE register and the ALL_GATED reduction.

## Test plan
- Reset: RST=1 for 2 edges, then REQ=0 -> E=4'b1111, RDY=4'b1111, SE=0 immediately after reset. E[0] falls after exactly 16 idle edges; GATED=4'b1111, ALL_GATED=1.
- Wake, domain 2 in OFF: REQ[2]=1 at edge k -> E[2]=1 after k, RDY[2]=0 after k+1, RDY[2]=1 after k+2. Other domains unchanged.
- Idle boundary: REQ[1] low for 15 edges, high on the 16th -> domain 1 stays RUN, cnt=0. Next 16 idle edges -> OFF.
- FORCE_ON[3]=1 with REQ=0 for 100 edges -> E[3]=1, RDY[3]=1 throughout; domains 0-2 gated.
- TEST_MODE=1 with all domains in OFF -> SE=1 and E=4'b1111 after 1 edge, held for 50 edges. After TEST_MODE falls, gating occurs 16 edges later.
- Abort and reset: REQ pulses for 1 cycle in OFF -> full WAKE to RUN, then gates again after 16 idle edges. RST asserted during WAKE -> RUN and RDY=1 the next edge.

Source files
------------

// File: rtl/clkgate_ctrl_pkg.sv
// Shared types and sizing helpers for the per-domain clock-gating controller.
package clkgate_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_OFF  = 2'd1,
    ST_WAKE = 2'd2
  } domState_e;

  typedef struct packed {
    logic e;
    logic rdy;
    logic gated;
  } domOut_t;

  localparam domOut_t OUT_RUN  = '{e: 1'b1, rdy: 1'b1, gated: 1'b0};
  localparam domOut_t OUT_OFF  = '{e: 1'b0, rdy: 1'b0, gated: 1'b1};
  localparam domOut_t OUT_WAKE = '{e: 1'b1, rdy: 1'b0, gated: 1'b0};

  // Counter must hold 0..max(IDLE,WAKE)-1; never narrower than one bit.
  function automatic int cntWidth(input int idleCycles, input int wakeCycles);
    int maxCycles;
    int w;
    maxCycles = (idleCycles > wakeCycles) ? idleCycles : wakeCycles;
    w = $clog2(maxCycles);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/clkgate_dom_fsm.sv
// Single clock domain: RUN/OFF/WAKE state machine with shared idle/wake counter.
module clkgate_dom_fsm
  import clkgate_ctrl_pkg::*;
#(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic i_ck,
  input  logic i_rst,
  input  logic i_testMode,
  input  logic i_act,
  output logic o_e,
  output logic o_rdy,
  output logic o_gated
);

  localparam int CNT_W = cntWidth(IDLE_CYCLES, WAKE_CYCLES);
  localparam logic [CNT_W-1:0] IDLE_LIM = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LIM = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  domState_e        r_state;
  domState_e        w_stateNext;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cntNext;
  domOut_t          r_out;
  domOut_t          w_outNext;

  // Outputs are registered alongside the state so E never glitches into the gating cell.
  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
      r_out   <= OUT_RUN;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
      r_out   <= w_outNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    if (i_testMode) begin
      w_stateNext = ST_RUN;
      w_cntNext   = '0;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (i_act) begin
            w_cntNext = '0;
          end else if (r_cnt == IDLE_LIM) begin
            w_stateNext = ST_OFF;
            w_cntNext   = '0;
          end else begin
            w_cntNext = r_cnt + CNT_ONE;
          end
        end
        ST_OFF: begin
          if (i_act) begin
            w_stateNext = ST_WAKE;
            w_cntNext   = '0;
          end
        end
        ST_WAKE: begin
          // A dropped request is not an abort; the domain finishes waking first.
          if (r_cnt == WAKE_LIM) begin
            w_stateNext = ST_RUN;
            w_cntNext   = '0;
          end else begin
            w_cntNext = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_stateNext = ST_RUN;
          w_cntNext   = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_outNext = OUT_RUN;
    unique case (w_stateNext)
      ST_RUN:  w_outNext = OUT_RUN;
      ST_OFF:  w_outNext = OUT_OFF;
      ST_WAKE: w_outNext = OUT_WAKE;
      default: w_outNext = OUT_RUN;
    endcase
  end

  assign o_e     = r_out.e;
  assign o_rdy   = r_out.rdy;
  assign o_gated = r_out.gated;

endmodule

// File: rtl/clkgate_ctrl.sv
// Bank of independent clock-gating domains plus the shared scan-enable register.
module clkgate_ctrl
  import clkgate_ctrl_pkg::*;
#(
  parameter int N_DOM       = 4,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic             i_ck,
  input  logic             i_rst,
  input  logic             i_testMode,
  input  logic [N_DOM-1:0] i_req,
  input  logic [N_DOM-1:0] i_forceOn,
  output logic [N_DOM-1:0] o_e,
  output logic             o_se,
  output logic [N_DOM-1:0] o_rdy,
  output logic [N_DOM-1:0] o_gated,
  output logic             o_allGated
);

  logic             r_se;
  logic [N_DOM-1:0] w_act;
  logic [N_DOM-1:0] w_gated;

  assign w_act = i_req | i_forceOn;

  for (genvar gi = 0; gi < N_DOM; gi++) begin : g_dom
    clkgate_dom_fsm #(
      .IDLE_CYCLES(IDLE_CYCLES),
      .WAKE_CYCLES(WAKE_CYCLES)
    ) u_dom (
      .i_ck      (i_ck),
      .i_rst     (i_rst),
      .i_testMode(i_testMode),
      .i_act     (w_act[gi]),
      .o_e       (o_e[gi]),
      .o_rdy     (o_rdy[gi]),
      .o_gated   (w_gated[gi])
    );
  end

  always_ff @(posedge i_ck) begin
    if (i_rst) begin
      r_se <= 1'b0;
    end else begin
      r_se <= i_testMode;
    end
  end

  // Reduction of already-registered flags, so no input-to-output path exists.
  assign o_se       = r_se;
  assign o_gated    = w_gated;
  assign o_allGated = &w_gated;

endmodule

// File: tb/tb_clkgate_ctrl.sv
// Directed and randomized checks of clkgate_ctrl against an idle/wake timing model.
module tb_clkgate_ctrl;

  localparam int N    = 4;
  localparam int IDLE = 16;
  localparam int WAKE = 2;

  logic         ck = 1'b0;
  logic         rst;
  logic         testMode;
  logic [N-1:0] req;
  logic [N-1:0] forceOn;
  logic [N-1:0] e;
  logic         se;
  logic [N-1:0] rdy;
  logic [N-1:0] gated;
  logic         allGated;

  int vectors     = 0;
  int miscompares = 0;

  // Model: consecutive idle samples while running, edges left until ready, off flag.
  int idleSeen[N];
  int wakeLeft[N];
  bit isOff[N];
  bit seModel;

  always #5 ck = ~ck;

  clkgate_ctrl #(
    .N_DOM(N),
    .IDLE_CYCLES(IDLE),
    .WAKE_CYCLES(WAKE)
  ) dut (
    .i_ck      (ck),
    .i_rst     (rst),
    .i_testMode(testMode),
    .i_req     (req),
    .i_forceOn (forceOn),
    .o_e       (e),
    .o_se      (se),
    .o_rdy     (rdy),
    .o_gated   (gated),
    .o_allGated(allGated)
  );

  always @(posedge ck) begin
    for (int i = 0; i < N; i++) begin
      if (rst || testMode) begin
        isOff[i]    = 1'b0;
        wakeLeft[i] = 0;
        idleSeen[i] = 0;
      end else if (isOff[i]) begin
        if (req[i] || forceOn[i]) begin
          isOff[i]    = 1'b0;
          wakeLeft[i] = WAKE;
          idleSeen[i] = 0;
        end
      end else if (wakeLeft[i] > 0) begin
        wakeLeft[i] = wakeLeft[i] - 1;
      end else if (req[i] || forceOn[i]) begin
        idleSeen[i] = 0;
      end else begin
        idleSeen[i] = idleSeen[i] + 1;
        if (idleSeen[i] == IDLE) begin
          isOff[i]    = 1'b1;
          idleSeen[i] = 0;
        end
      end
    end
    seModel = rst ? 1'b0 : testMode;
  end

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; testMode = 1'b0; req = '0; forceOn = '0;
    tick(); tick();
    vectors++;
    if (e !== 4'b1111) begin miscompares++; $display("[TB] FAIL reset_e: got %b, expected %b", e, 4'b1111); end
    vectors++;
    if (rdy !== 4'b1111) begin miscompares++; $display("[TB] FAIL reset_rdy: got %b, expected %b", rdy, 4'b1111); end
    vectors++;
    if (se !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_se: got %b, expected 0", se); end
    vectors++;
    if (gated !== 4'b0000 || allGated !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_gated: got %b/%b, expected 0000/0", gated, allGated);
    end
    rst = 1'b0;
    for (int k = 1; k <= IDLE; k++) begin
      tick();
      if (k < IDLE) begin
        vectors++;
        if (e !== 4'b1111) begin miscompares++; $display("[TB] FAIL idle_hold_%0d: got %b, expected 1111", k, e); end
      end
    end
    vectors++;
    if (e !== 4'b0000) begin miscompares++; $display("[TB] FAIL idle_gate_e: got %b, expected 0000", e); end
    vectors++;
    if (gated !== 4'b1111 || allGated !== 1'b1) begin
      miscompares++; $display("[TB] FAIL idle_gate_all: got %b/%b, expected 1111/1", gated, allGated);
    end
  endtask

  task automatic test_wake();
    req = 4'b0100;
    tick();
    vectors++;
    if (e !== 4'b0100 || rdy !== 4'b0000) begin
      miscompares++; $display("[TB] FAIL wake_k: got e=%b rdy=%b, expected e=0100 rdy=0000", e, rdy);
    end
    tick();
    vectors++;
    if (e !== 4'b0100 || rdy !== 4'b0000) begin
      miscompares++; $display("[TB] FAIL wake_k1: got e=%b rdy=%b, expected e=0100 rdy=0000", e, rdy);
    end
    tick();
    vectors++;
    if (e !== 4'b0100 || rdy !== 4'b0100 || gated !== 4'b1011) begin
      miscompares++; $display("[TB] FAIL wake_k2: got e=%b rdy=%b gated=%b, expected 0100 0100 1011", e, rdy, gated);
    end
  endtask

  task automatic test_idle_boundary();
    req = 4'b0010;
    tick(); tick(); tick();
    vectors++;
    if (rdy[1] !== 1'b1) begin miscompares++; $display("[TB] FAIL bnd_awake: got %b, expected 1", rdy[1]); end
    req = 4'b0000;
    for (int k = 0; k < IDLE - 1; k++) tick();
    req = 4'b0010;
    tick();
    vectors++;
    if (e[1] !== 1'b1 || rdy[1] !== 1'b1) begin
      miscompares++; $display("[TB] FAIL bnd_rescue: got e=%b rdy=%b, expected 1 1", e[1], rdy[1]);
    end
    req = 4'b0000;
    for (int k = 1; k <= IDLE; k++) begin
      tick();
      if (k == IDLE - 1) begin
        vectors++;
        if (e[1] !== 1'b1) begin miscompares++; $display("[TB] FAIL bnd_last_run: got %b, expected 1", e[1]); end
      end
    end
    vectors++;
    if (e[1] !== 1'b0 || gated[1] !== 1'b1) begin
      miscompares++; $display("[TB] FAIL bnd_off: got e=%b gated=%b, expected 0 1", e[1], gated[1]);
    end
  endtask

  task automatic test_force_on();
    int bad;
    bad = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    req = '0; forceOn = 4'b1000;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (e[3] !== 1'b1 || rdy[3] !== 1'b1) bad++;
    end
    vectors++;
    if (bad != 0) begin miscompares++; $display("[TB] FAIL force_hold: got %0d bad edges, expected 0", bad); end
    vectors++;
    if (e !== 4'b1000 || gated !== 4'b0111) begin
      miscompares++; $display("[TB] FAIL force_others: got e=%b gated=%b, expected 1000 0111", e, gated);
    end
  endtask

  task automatic test_test_mode();
    int bad;
    bad = 0;
    forceOn = '0;
    for (int k = 0; k < IDLE; k++) tick();
    vectors++;
    if (allGated !== 1'b1) begin miscompares++; $display("[TB] FAIL tm_pre: got %b, expected 1", allGated); end
    testMode = 1'b1;
    tick();
    vectors++;
    if (se !== 1'b1 || e !== 4'b1111 || rdy !== 4'b1111) begin
      miscompares++; $display("[TB] FAIL tm_enter: got se=%b e=%b rdy=%b, expected 1 1111 1111", se, e, rdy);
    end
    for (int k = 1; k < 50; k++) begin
      tick();
      if (se !== 1'b1 || e !== 4'b1111) bad++;
    end
    vectors++;
    if (bad != 0) begin miscompares++; $display("[TB] FAIL tm_hold: got %0d bad edges, expected 0", bad); end
    testMode = 1'b0;
    for (int k = 1; k <= IDLE; k++) begin
      tick();
      if (k == 1) begin
        vectors++;
        if (se !== 1'b0) begin miscompares++; $display("[TB] FAIL tm_exit_se: got %b, expected 0", se); end
      end
      if (k == IDLE - 1) begin
        vectors++;
        if (e !== 4'b1111) begin miscompares++; $display("[TB] FAIL tm_exit_run: got %b, expected 1111", e); end
      end
    end
    vectors++;
    if (e !== 4'b0000) begin miscompares++; $display("[TB] FAIL tm_exit_gate: got %b, expected 0000", e); end
  endtask

  task automatic test_abort_reset();
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    vectors++;
    if (e !== 4'b0001 || rdy !== 4'b0000) begin
      miscompares++; $display("[TB] FAIL pulse_wake: got e=%b rdy=%b, expected 0001 0000", e, rdy);
    end
    tick();
    vectors++;
    if (rdy !== 4'b0001) begin miscompares++; $display("[TB] FAIL pulse_run: got %b, expected 0001", rdy); end
    for (int k = 1; k <= IDLE; k++) begin
      tick();
      if (k == IDLE - 1) begin
        vectors++;
        if (e[0] !== 1'b1) begin miscompares++; $display("[TB] FAIL pulse_last_run: got %b, expected 1", e[0]); end
      end
    end
    vectors++;
    if (e[0] !== 1'b0) begin miscompares++; $display("[TB] FAIL pulse_regate: got %b, expected 0", e[0]); end
    req = 4'b0001;
    tick();
    req = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (e !== 4'b1111 || rdy !== 4'b1111) begin
      miscompares++; $display("[TB] FAIL rst_in_wake: got e=%b rdy=%b, expected 1111 1111", e, rdy);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] expE, expR, expG;
    for (int t = 0; t < 2000; t++) begin
      rst = ($urandom_range(0, 149) == 0);
      if (testMode) testMode = ($urandom_range(0, 4) != 0);
      else          testMode = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < N; i++) begin
        req[i]     = ($urandom_range(0, 24) == 0);
        forceOn[i] = ($urandom_range(0, 199) == 0);
      end
      tick();
      for (int i = 0; i < N; i++) begin
        expE[i] = !isOff[i];
        expR[i] = !isOff[i] && (wakeLeft[i] == 0);
        expG[i] = isOff[i];
      end
      vectors++;
      if (e !== expE) begin miscompares++; $display("[TB] FAIL rnd_e t=%0d: got %b, expected %b", t, e, expE); end
      vectors++;
      if (rdy !== expR) begin miscompares++; $display("[TB] FAIL rnd_rdy t=%0d: got %b, expected %b", t, rdy, expR); end
      vectors++;
      if (gated !== expG || allGated !== (&expG)) begin
        miscompares++; $display("[TB] FAIL rnd_gated t=%0d: got %b/%b, expected %b/%b", t, gated, allGated, expG, &expG);
      end
      vectors++;
      if (se !== seModel) begin miscompares++; $display("[TB] FAIL rnd_se t=%0d: got %b, expected %b", t, se, seModel); end
    end
    rst = 1'b0; testMode = 1'b0; req = '0; forceOn = '0;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      idleSeen[i] = 0;
      wakeLeft[i] = 0;
      isOff[i]    = 1'b0;
    end
    seModel = 1'b0;
    test_reset();
    test_wake();
    test_idle_boundary();
    test_force_on();
    test_test_mode();
    test_abort_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
